vertexinput_stream_ctrl: RTL and testbench

- Logic-side consumer of the vertexinput config/status register pair.
- Decodes the config word written by the AXI-lite memory model: start, abort, vertex count and stride.
- Emits a valid/ready stream of vertex indices and byte offsets to the downstream vertex fetch stage.
- Writes live status (busy, done, aborted, error, progress count) back into the status word.

---
 rtl/vertexinput_reg_if.sv | 26 ++
 rtl/vertexinput_stream_ctrl.sv | 158 +++++++++++++++
 tb/tb_vertexinput_stream_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/vertexinput_reg_if.sv
//==============================================================================
// Module  : vertexinput_reg_if
// Brief   : Config/status register pair shared between the AXI-lite memory
//           model and the vertexinput logic.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

interface vertexinput_reg_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] data_mem2logic;
  logic [DATA_W-1:0] data_logic2mem;

  modport logic_side (
    input  data_mem2logic,
    output data_logic2mem
  );

  modport mem_side (
    output data_mem2logic,
    input  data_logic2mem
  );
endinterface

`default_nettype wire

// File: rtl/vertexinput_stream_ctrl.sv
//==============================================================================
// Module  : vertexinput_stream_ctrl
// Brief   : Decodes the vertexinput config word, streams vertex index/offset
//           pairs downstream and reports job status.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module vertexinput_stream_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  vertexinput_reg_if.logic_side regs,
  output logic                  vtx_valid,
  input  logic                  vtx_ready,
  output logic [CNT_W-1:0]      vtx_index,
  output logic [DATA_W-1:0]     vtx_offset,
  output logic                  vtx_last
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_RUN  = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_start_d;
  logic [CNT_W-1:0]  r_count;
  logic [7:0]        r_stride;
  logic [CNT_W-1:0]  r_index;
  logic [DATA_W-1:0] r_offset;
  logic [CNT_W-1:0]  r_emitted;
  logic              r_done;
  logic              r_aborted;
  logic              r_err;

  logic              w_start_edge;
  logic              w_abort;
  logic [7:0]        w_cfg_stride;
  logic [CNT_W-1:0]  w_cfg_count;
  logic              w_run;
  logic              w_fire;
  logic              w_last;
  logic              w_launch;
  logic [DATA_W-1:0] w_status;
  logic              w_unused_cfg;

  assign w_start_edge = regs.data_mem2logic[0] & ~r_start_d;
  assign w_abort      = regs.data_mem2logic[1];
  assign w_cfg_stride = regs.data_mem2logic[11:4];
  assign w_cfg_count  = regs.data_mem2logic[16 +: CNT_W];
  assign w_unused_cfg = ^regs.data_mem2logic;

  assign w_run    = (r_state == c_ST_RUN);
  assign w_fire   = w_run & vtx_ready;
  assign w_last   = w_run && (r_index == (r_count - CNT_W'(1)));
  // Abort wins over a coincident start edge, so no job launches.
  assign w_launch = (r_state == c_ST_IDLE) & w_start_edge & ~w_abort;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_launch && (w_cfg_count != '0)) begin
          w_state_nxt = c_ST_RUN;
        end
      end
      c_ST_RUN: begin
        if (w_abort) begin
          w_state_nxt = c_ST_IDLE;
        end else if (w_fire && w_last) begin
          w_state_nxt = c_ST_DONE;
        end
      end
      c_ST_DONE: w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Job datapath: latched config, running index/offset and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_d <= 1'b0;
      r_count   <= '0;
      r_stride  <= '0;
      r_index   <= '0;
      r_offset  <= '0;
      r_emitted <= '0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_start_d <= regs.data_mem2logic[0];
      case (r_state)
        c_ST_IDLE: begin
          if (w_launch) begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_emitted <= '0;
            if (w_cfg_count == '0) begin
              r_err <= 1'b1;
            end else begin
              r_err    <= 1'b0;
              r_count  <= w_cfg_count;
              r_stride <= w_cfg_stride;
              r_index  <= '0;
              r_offset <= '0;
            end
          end
        end
        c_ST_RUN: begin
          // A handshake in the abort cycle still completes and is counted.
          if (w_fire) begin
            r_emitted <= r_emitted + CNT_W'(1);
            r_index   <= r_index + CNT_W'(1);
            r_offset  <= r_offset + DATA_W'(r_stride);
          end
          if (w_abort) begin
            r_aborted <= 1'b1;
          end else if (w_fire && w_last) begin
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    w_status                 = '0;
    w_status[0]              = w_run;
    w_status[1]              = r_done;
    w_status[2]              = r_aborted;
    w_status[3]              = r_err;
    w_status[16 +: CNT_W]    = r_emitted;
    regs.data_logic2mem      = w_status;
    vtx_valid                = w_run;
    vtx_index                = r_index;
    vtx_offset               = r_offset;
    vtx_last                 = w_last;
  end

endmodule

`default_nettype wire

// File: tb/tb_vertexinput_stream_ctrl.sv
//==============================================================================
// Module  : tb_vertexinput_stream_ctrl
// Brief   : Directed self-checking bench for vertexinput_stream_ctrl.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_vertexinput_stream_ctrl;

  logic        clk;
  logic        rst;
  logic        vtx_valid;
  logic        vtx_ready;
  logic [15:0] vtx_index;
  logic [31:0] vtx_offset;
  logic        vtx_last;

  int errors = 0;
  int checks = 0;

  vertexinput_reg_if #(.DATA_W(32)) regs_if ();

  vertexinput_stream_ctrl #(.DATA_W(32), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .regs       (regs_if),
    .vtx_valid  (vtx_valid),
    .vtx_ready  (vtx_ready),
    .vtx_index  (vtx_index),
    .vtx_offset (vtx_offset),
    .vtx_last   (vtx_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cfg(input int count, input int stride,
                                      input bit abort, input bit start);
    return (32'(count) << 16) | (32'(stride) << 4) | (32'(abort) << 1) | 32'(start);
  endfunction

  initial begin
    int pat [6] = '{1, 0, 0, 1, 0, 1};
    int hs;

    rst = 1'b1;
    vtx_ready = 1'b0;
    regs_if.data_mem2logic = '0;
    #1;
    check("rst_valid", vtx_valid, 0);
    check("rst_status", regs_if.data_logic2mem, 0);
    tick();
    rst = 1'b0;
    tick();
    check("idle_status", regs_if.data_logic2mem, 0);
    check("idle_last", vtx_last, 0);

    // Basic job: count 4, stride 16
    vtx_ready = 1'b1;
    regs_if.data_mem2logic = cfg(4, 16, 0, 1);
    tick();
    check("basic_busy", regs_if.data_logic2mem, 32'h0000_0001);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("basic_valid%0d", i), vtx_valid, 1);
      check($sformatf("basic_index%0d", i), vtx_index, i);
      check($sformatf("basic_offset%0d", i), vtx_offset, 16 * i);
      check($sformatf("basic_last%0d", i), vtx_last, (i == 3));
      tick();
    end
    check("basic_done_valid", vtx_valid, 0);
    check("basic_done_status", regs_if.data_logic2mem, 32'h0004_0002);
    regs_if.data_mem2logic = '0;
    tick();
    check("basic_sticky", regs_if.data_logic2mem, 32'h0004_0002);

    // Backpressure: count 3, stride 8
    vtx_ready = 1'b0;
    regs_if.data_mem2logic = cfg(3, 8, 0, 1);
    tick();
    hs = 0;
    for (int c = 0; c < 6; c++) begin
      vtx_ready = pat[c][0];
      check($sformatf("bp_valid%0d", c), vtx_valid, 1);
      check($sformatf("bp_index%0d", c), vtx_index, hs);
      check($sformatf("bp_offset%0d", c), vtx_offset, 8 * hs);
      check($sformatf("bp_last%0d", c), vtx_last, (hs == 2));
      tick();
      if (pat[c] != 0) hs++;
    end
    check("bp_done_valid", vtx_valid, 0);
    check("bp_status", regs_if.data_logic2mem, 32'h0003_0002);
    vtx_ready = 1'b0;
    regs_if.data_mem2logic = '0;
    tick();

    // Abort after 5 handshakes
    vtx_ready = 1'b1;
    regs_if.data_mem2logic = cfg(100, 4, 0, 1);
    tick();
    repeat (5) tick();
    vtx_ready = 1'b0;
    regs_if.data_mem2logic = cfg(100, 4, 1, 1);
    check("abort_pre_valid", vtx_valid, 1);
    check("abort_pre_index", vtx_index, 5);
    check("abort_pre_offset", vtx_offset, 20);
    check("abort_pre_status", regs_if.data_logic2mem, 32'h0005_0001);
    tick();
    check("abort_valid", vtx_valid, 0);
    check("abort_status", regs_if.data_logic2mem, 32'h0005_0004);
    regs_if.data_mem2logic = '0;
    tick();
    // Abort together with a start edge in IDLE launches nothing
    regs_if.data_mem2logic = cfg(5, 4, 1, 1);
    tick();
    check("abort_start_valid", vtx_valid, 0);
    check("abort_start_status", regs_if.data_logic2mem, 32'h0005_0004);
    regs_if.data_mem2logic = '0;
    tick();

    // Zero count then a valid count-2 job
    regs_if.data_mem2logic = cfg(0, 4, 0, 1);
    tick();
    check("zero_valid", vtx_valid, 0);
    check("zero_status", regs_if.data_logic2mem, 32'h0000_0008);
    tick();
    check("zero_valid2", vtx_valid, 0);
    regs_if.data_mem2logic = '0;
    tick();
    vtx_ready = 1'b1;
    regs_if.data_mem2logic = cfg(2, 1, 0, 1);
    tick();
    check("zero_next_status", regs_if.data_logic2mem, 32'h0000_0001);
    check("zero_next_index0", vtx_index, 0);
    tick();
    check("zero_next_index1", vtx_index, 1);
    check("zero_next_offset1", vtx_offset, 1);
    check("zero_next_last1", vtx_last, 1);
    tick();
    check("zero_next_done", regs_if.data_logic2mem, 32'h0002_0002);
    regs_if.data_mem2logic = '0;
    tick();

    // Restart ignored in RUN, config changes do not affect a running job
    vtx_ready = 1'b0;
    regs_if.data_mem2logic = cfg(3, 2, 0, 1);
    tick();
    regs_if.data_mem2logic = cfg(10, 2, 0, 0);
    tick();
    regs_if.data_mem2logic = cfg(10, 6, 0, 1);
    vtx_ready = 1'b1;
    check("rs_index0", vtx_index, 0);
    tick();
    check("rs_index1", vtx_index, 1);
    check("rs_offset1", vtx_offset, 2);
    check("rs_last1", vtx_last, 0);
    tick();
    check("rs_offset2", vtx_offset, 4);
    check("rs_last2", vtx_last, 1);
    tick();
    check("rs_done", regs_if.data_logic2mem, 32'h0003_0002);
    tick();
    tick();
    check("rs_hold_valid", vtx_valid, 0);
    check("rs_hold_status", regs_if.data_logic2mem, 32'h0003_0002);
    regs_if.data_mem2logic = cfg(2, 2, 0, 0);
    tick();
    regs_if.data_mem2logic = cfg(2, 2, 0, 1);
    tick();
    check("rs_relaunch_valid", vtx_valid, 1);
    check("rs_relaunch_status", regs_if.data_logic2mem, 32'h0000_0001);

    // Asynchronous reset in the middle of a job
    tick();
    check("mid_index", vtx_index, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", vtx_valid, 0);
    check("arst_status", regs_if.data_logic2mem, 0);
    check("arst_index", vtx_index, 0);
    check("arst_offset", vtx_offset, 0);
    check("arst_last", vtx_last, 0);
    regs_if.data_mem2logic = '0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("post_rst_valid", vtx_valid, 0);
    check("post_rst_status", regs_if.data_logic2mem, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
